// File: rtl/spi_target_pkg.sv
// Shared types and constants for the byte-oriented SPI target.
//   state_e         : engine state (idle / transfer in progress)
//   IdleByteDefault : byte sent on CIPO when the fabric has nothing queued
//   CopiIdx/CipoIdx : lane positions of COPI/CIPO on the 4-bit data pins
package spi_target_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  localparam logic [7:0]  IdleByteDefault = 8'hFF;
  localparam int unsigned CopiIdx         = 0;
  localparam int unsigned CipoIdx         = 1;

endpackage

// File: rtl/spi_target_byte_if.sv
// Fabric-side byte streams of the SPI target.
//   rx_data/rx_valid/rx_ready : received bytes towards the consumer
//   tx_data/tx_valid/tx_ready : bytes to transmit from the producer
// slave is the SPI target side, master is the fabric side.
interface spi_target_byte_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for asynchronous inputs.
//   clk_i/rst_ni : destination clock, async active-low reset
//   d_i          : asynchronous input
//   q_o          : synchronised output (resets to ResetValue)
module prim_flop_2sync #(
  parameter int unsigned     Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_target_shift.sv
// Bit counter and RX/TX shift registers of the SPI target.
//   start_i     : transfer begins (counter cleared, first TX load for CPHA=0)
//   sample_i    : sample strobe, shifts copi_i into the RX register
//   drive_i     : drive strobe, shifts or reloads the TX register
//   load_byte_i : byte to use when the TX register is (re)loaded
//   tx_load_o   : TX register consumes load_byte_i this cycle
//   rx_done_o   : eighth bit sampled this cycle, rx_byte_o is complete
//   cipo_o      : current outgoing bit (MSB of TX register)
module spi_target_shift #(
  parameter logic CPHA = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       sample_i,
  input  logic       drive_i,
  input  logic       copi_i,
  input  logic [7:0] load_byte_i,
  output logic       tx_load_o,
  output logic       rx_done_o,
  output logic [7:0] rx_byte_o,
  output logic       cipo_o
);

  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  // Set at a byte boundary: the next drive edge reloads instead of shifting.
  logic       pend_q, pend_d;

  always_comb begin
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    pend_d    = pend_q;
    tx_load_o = 1'b0;
    rx_done_o = 1'b0;
    rx_byte_o = {rx_q[6:0], copi_i};
    if (start_i) begin
      cnt_d  = 3'd0;
      // CPHA=1 has no bit on the wire until the first leading edge.
      pend_d = CPHA;
      if (!CPHA) begin
        tx_d      = load_byte_i;
        tx_load_o = 1'b1;
      end
    end else begin
      if (drive_i) begin
        if (pend_q) begin
          tx_d      = load_byte_i;
          tx_load_o = 1'b1;
          pend_d    = 1'b0;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      if (sample_i) begin
        rx_d  = {rx_q[6:0], copi_i};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          rx_done_o = 1'b1;
          pend_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 3'd0;
      rx_q   <= 8'h00;
      tx_q   <= 8'h00;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      pend_q <= pend_d;
    end
  end

  assign cipo_o = tx_q[7];

endmodule

// File: rtl/spi_target_byte.sv
// Byte-oriented SPI target engine, oversampling the SPI pins in clk_i.
//   clk_i/rst_ni      : system clock, async active-low reset
//   en_i              : block enable
//   cio_sck_i/csb_i   : SPI clock and active-low chip select from the host
//   cio_sd_i          : data pins in (COPI on bit 0)
//   cio_sd_o/sd_en_o  : data pins out and enables (CIPO on bit 1)
//   fab               : RX/TX byte streams towards the fabric
//   active_o          : transfer in progress
//   rx_overflow_o     : pulse, completed byte dropped (RX holding full)
//   tx_underflow_o    : pulse, IdleByte sent because TX holding was empty
module spi_target_byte
  import spi_target_pkg::*;
#(
  parameter logic       CPOL     = 1'b0,
  parameter logic       CPHA     = 1'b0,
  parameter logic [7:0] IdleByte = IdleByteDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             cio_sck_i,
  input  logic             cio_csb_i,
  input  logic [3:0]       cio_sd_i,
  output logic [3:0]       cio_sd_o,
  output logic [3:0]       cio_sd_en_o,
  spi_target_byte_if.slave fab,
  output logic             active_o,
  output logic             rx_overflow_o,
  output logic             tx_underflow_o
);

  logic sck_s, csb_s, copi_s;
  logic sck_prev_q, csb_prev_q;
  logic unused_sd;

  assign unused_sd = ^cio_sd_i[3:1];

  prim_flop_2sync #(
    .Width     (3),
    .ResetValue({CPOL, 1'b1, 1'b0})
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   ({cio_sck_i, cio_csb_i, cio_sd_i[CopiIdx]}),
    .q_o   ({sck_s, csb_s, copi_s})
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_prev_q <= CPOL;
      csb_prev_q <= 1'b1;
    end else begin
      sck_prev_q <= sck_s;
      csb_prev_q <= csb_s;
    end
  end

  logic sck_edge, lead_edge, trail_edge, csb_fall, csb_rise;
  assign sck_edge   = sck_s ^ sck_prev_q;
  assign lead_edge  = sck_edge & (sck_prev_q == CPOL);
  assign trail_edge = sck_edge & (sck_prev_q != CPOL);
  assign csb_fall   = csb_prev_q & ~csb_s;
  assign csb_rise   = ~csb_prev_q & csb_s;

  state_e state_q, state_d;
  logic   start, run, sample, drive;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en_i && csb_fall) state_d = StActive;
      StActive: if (!en_i || csb_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  assign start  = (state_q == StIdle) & en_i & csb_fall;
  assign run    = (state_q == StActive) & en_i & ~csb_rise;
  assign sample = run & (CPHA ? trail_edge : lead_edge);
  assign drive  = run & (CPHA ? lead_edge : trail_edge);

  logic [7:0] tx_hold_q, tx_hold_d, load_byte, rx_byte, rx_data_q, rx_data_d;
  logic       tx_full_q, tx_full_d, tx_load, rx_done, cipo;
  logic       rx_valid_q, rx_valid_d, ovf_q, ovf_d, udf_q, udf_d;

  assign load_byte = tx_full_q ? tx_hold_q : IdleByte;

  spi_target_shift #(
    .CPHA(CPHA)
  ) u_shift (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start),
    .sample_i   (sample),
    .drive_i    (drive),
    .copi_i     (copi_s),
    .load_byte_i(load_byte),
    .tx_load_o  (tx_load),
    .rx_done_o  (rx_done),
    .rx_byte_o  (rx_byte),
    .cipo_o     (cipo)
  );

  always_comb begin
    // A write landing with a reload is too late for it; it stays queued.
    tx_full_d  = (fab.tx_valid & ~tx_full_q) | (tx_full_q & ~tx_load);
    tx_hold_d  = (fab.tx_valid & ~tx_full_q) ? fab.tx_data : tx_hold_q;
    udf_d      = tx_load & ~tx_full_q;
    rx_valid_d = rx_valid_q & ~fab.rx_ready;
    rx_data_d  = rx_data_q;
    ovf_d      = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || fab.rx_ready) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_hold_q  <= 8'h00;
      tx_full_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign active_o       = (state_q == StActive) & en_i;
  assign fab.rx_data    = rx_data_q;
  assign fab.rx_valid   = rx_valid_q;
  assign fab.tx_ready   = ~tx_full_q;
  assign rx_overflow_o  = ovf_q;
  assign tx_underflow_o = udf_q;

  always_comb begin
    cio_sd_o              = 4'b0000;
    cio_sd_o[CipoIdx]     = active_o & cipo;
    cio_sd_en_o           = 4'b0000;
    cio_sd_en_o[CipoIdx]  = active_o;
  end

endmodule

// File: tb/tb_spi_target_byte.sv
module tb_spi_target_byte;

  localparam int H = 6;

  logic clk, rst_n;
  logic en0, sck0, csb0, act0, ovf0, uf0;
  logic en3, sck3, csb3, act3, ovf3, uf3;
  logic [3:0] sdi0, sdo0, sden0, sdi3, sdo3, sden3;

  spi_target_byte_if fab0 ();
  spi_target_byte_if fab3 ();

  spi_target_byte #(.CPOL(1'b0), .CPHA(1'b0), .IdleByte(8'hFF)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en0), .cio_sck_i(sck0), .cio_csb_i(csb0),
    .cio_sd_i(sdi0), .cio_sd_o(sdo0), .cio_sd_en_o(sden0), .fab(fab0),
    .active_o(act0), .rx_overflow_o(ovf0), .tx_underflow_o(uf0)
  );

  spi_target_byte #(.CPOL(1'b1), .CPHA(1'b1), .IdleByte(8'hFF)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en3), .cio_sck_i(sck3), .cio_csb_i(csb3),
    .cio_sd_i(sdi3), .cio_sd_o(sdo3), .cio_sd_en_o(sden3), .fab(fab3),
    .active_o(act3), .rx_overflow_o(ovf3), .tx_underflow_o(uf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event counters, sampled on the inactive edge.
  int ufc0 = 0, ovc0 = 0, rxc0 = 0, ufc3 = 0, rxc3 = 0;
  logic [7:0] last_rx0 = 8'h00;
  logic [7:0] rxq3[$];

  always @(negedge clk) begin
    if (uf0) ufc0++;
    if (ovf0) ovc0++;
    if (uf3) ufc3++;
    if (fab0.rx_valid && fab0.rx_ready) begin
      rxc0++;
      last_rx0 = fab0.rx_data;
    end
    if (fab3.rx_valid && fab3.rx_ready) begin
      rxc3++;
      rxq3.push_back(fab3.rx_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input bit m3, input logic [7:0] d);
    int n = 0;
    while (!(m3 ? fab3.tx_ready : fab0.tx_ready) && n < 50) begin
      wait_clk(1);
      n++;
    end
    chk("tx_ready_before_write", m3 ? fab3.tx_ready : fab0.tx_ready, 1);
    if (m3) begin fab3.tx_data = d; fab3.tx_valid = 1'b1; end
    else    begin fab0.tx_data = d; fab0.tx_valid = 1'b1; end
    wait_clk(1);
    fab0.tx_valid = 1'b0;
    fab3.tx_valid = 1'b0;
  endtask

  // Host side: mode 0 on DUT0, mode 3 on DUT3, MSB first.
  task automatic xfer(input bit m3, input logic [7:0] mosi, input int nbits,
                      output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!m3) begin
        sdi0[0] = mosi[7-i];
        wait_clk(H);
        miso[7-i] = sdo0[1];
        sck0 = 1'b1;
        wait_clk(H);
        sck0 = 1'b0;
      end else begin
        sck3 = 1'b0;
        sdi3[0] = mosi[7-i];
        wait_clk(H);
        miso[7-i] = sdo3[1];
        sck3 = 1'b1;
        wait_clk(H);
      end
    end
  endtask

  initial begin
    logic [7:0] miso;
    logic [7:0] host_b [4];
    logic [7:0] dev_b [4];
    int s_uf, s_rx, s_ov;

    host_b = '{8'h5A, 8'hC3, 8'h0F, 8'h96};
    dev_b  = '{8'h81, 8'h42, 8'hE1, 8'h7E};

    rst_n = 1'b0;
    en0 = 1'b1; sck0 = 1'b0; csb0 = 1'b1; sdi0 = 4'h0;
    en3 = 1'b1; sck3 = 1'b1; csb3 = 1'b1; sdi3 = 4'h0;
    fab0.tx_valid = 1'b0; fab0.tx_data = 8'h00; fab0.rx_ready = 1'b1;
    fab3.tx_valid = 1'b0; fab3.tx_data = 8'h00; fab3.rx_ready = 1'b1;

    // Reset values
    wait_clk(2);
    chk("rst_sd_o", sdo0, 4'h0);
    chk("rst_sd_en", sden0, 4'h0);
    chk("rst_rx_data", fab0.rx_data, 8'h00);
    chk("rst_rx_valid", fab0.rx_valid, 0);
    chk("rst_tx_ready", fab0.tx_ready, 1);
    chk("rst_active", act0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", uf0, 0);
    chk("rst_m3_sd_en", sden3, 4'h0);
    chk("rst_m3_tx_ready", fab3.tx_ready, 1);
    rst_n = 1'b1;
    wait_clk(4);

    // Mode 0: host sends A5, target answers 3C
    tx_write(0, 8'h3C);
    chk("m0_tx_ready_full", fab0.tx_ready, 0);
    s_uf = ufc0; s_rx = rxc0;
    csb0 = 1'b0;
    wait_clk(H);
    chk("m0_active", act0, 1);
    chk("m0_sd_en", sden0, 4'b0010);
    chk("m0_hold_consumed", fab0.tx_ready, 1);
    chk("m0_no_udf_entry", ufc0 - s_uf, 0);
    xfer(0, 8'hA5, 8, miso);
    wait_clk(H);
    chk("m0_cipo_byte", miso, 8'h3C);
    chk("m0_rx_count", rxc0 - s_rx, 1);
    chk("m0_rx_data", last_rx0, 8'hA5);
    chk("m0_udf_boundary_reload", ufc0 - s_uf, 1);
    csb0 = 1'b1;
    wait_clk(H);
    chk("m0_sd_en_off", sden0, 4'h0);

    // Empty TX holding at CSB fall: IdleByte, one underflow at entry
    s_uf = ufc0;
    csb0 = 1'b0;
    wait_clk(H);
    chk("udf_entry_pulse", ufc0 - s_uf, 1);
    xfer(0, 8'h00, 8, miso);
    chk("udf_cipo_idle", miso, 8'hFF);
    wait_clk(H);
    csb0 = 1'b1;
    wait_clk(H);

    // Overflow: consumer stalled across two bytes
    fab0.rx_ready = 1'b0;
    s_ov = ovc0;
    csb0 = 1'b0; wait_clk(H);
    xfer(0, 8'h11, 8, miso);
    wait_clk(H); csb0 = 1'b1; wait_clk(H);
    chk("ovf_first_valid", fab0.rx_valid, 1);
    chk("ovf_first_data", fab0.rx_data, 8'h11);
    csb0 = 1'b0; wait_clk(H);
    xfer(0, 8'h22, 8, miso);
    wait_clk(H); csb0 = 1'b1; wait_clk(H);
    chk("ovf_data_kept", fab0.rx_data, 8'h11);
    chk("ovf_pulse", ovc0 - s_ov, 1);
    fab0.rx_ready = 1'b1;
    wait_clk(2);
    chk("ovf_drained_valid", fab0.rx_valid, 0);
    chk("ovf_drained_data", last_rx0, 8'h11);

    // CSB raised after 5 bits
    s_rx = rxc0;
    csb0 = 1'b0; wait_clk(H);
    xfer(0, 8'hE7, 5, miso);
    wait_clk(H);
    csb0 = 1'b1;
    wait_clk(3);
    chk("abort_sd_en", sden0, 4'h0);
    chk("abort_active", act0, 0);
    wait_clk(H);
    chk("abort_no_rx", rxc0 - s_rx, 0);
    csb0 = 1'b0; wait_clk(H);
    xfer(0, 8'h5C, 8, miso);
    wait_clk(H); csb0 = 1'b1; wait_clk(H);
    chk("abort_realign_data", last_rx0, 8'h5C);
    chk("abort_realign_count", rxc0 - s_rx, 1);

    // Disabled block ignores CSB
    en0 = 1'b0;
    csb0 = 1'b0;
    wait_clk(H);
    chk("dis_active", act0, 0);
    chk("dis_sd_en", sden0, 4'h0);
    en0 = 1'b1;
    wait_clk(H);
    chk("dis_no_start_without_fall", act0, 0);
    csb0 = 1'b1;
    wait_clk(H);

    // Mode 3: 4-byte burst with TX refilled before each byte
    s_uf = ufc3; s_rx = rxc3;
    tx_write(1, dev_b[0]);
    csb3 = 1'b0;
    wait_clk(H);
    chk("m3_active", act3, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tx_write(1, dev_b[k]);
      xfer(1, host_b[k], 8, miso);
      chk($sformatf("m3_miso%0d", k), miso, dev_b[k]);
    end
    wait_clk(H);
    csb3 = 1'b1;
    wait_clk(H);
    chk("m3_rx_count", rxc3 - s_rx, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("m3_rx%0d", k), rxq3[k], host_b[k]);
    chk("m3_no_udf", ufc3 - s_uf, 0);

    // Reset asserted mid-byte
    tx_write(0, 8'h99);
    csb0 = 1'b0;
    wait_clk(H);
    tx_write(0, 8'h66);
    chk("rstmid_hold_full", fab0.tx_ready, 0);
    xfer(0, 8'hF0, 4, miso);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sd_en", sden0, 4'h0);
    chk("rstmid_sd_o", sdo0, 4'h0);
    chk("rstmid_active", act0, 0);
    chk("rstmid_rx_valid", fab0.rx_valid, 0);
    chk("rstmid_tx_ready", fab0.tx_ready, 1);
    csb0 = 1'b1; sck0 = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
